// File: rtl/seg_scan_ctrl.sv
// Four-digit seven-segment controller: serial double-dabble BCD conversion plus a blanked digit scan.
// Build option: define SEG_LZB_EN to blank leading zeros on the upper three digits.

module seg_glyph (
  input  logic [3:0] digit,
  input  logic       ovf,
  input  logic       blank,
  output logic [7:0] glyph
);
  always_comb begin
    glyph = 8'h00;
    if (ovf) begin
      glyph = 8'h40;
    end else if (!blank) begin
      unique case (digit)
        4'd0:    glyph = 8'h3F;
        4'd1:    glyph = 8'h06;
        4'd2:    glyph = 8'h5B;
        4'd3:    glyph = 8'h4F;
        4'd4:    glyph = 8'h66;
        4'd5:    glyph = 8'h6D;
        4'd6:    glyph = 8'h7D;
        4'd7:    glyph = 8'h07;
        4'd8:    glyph = 8'h7F;
        4'd9:    glyph = 8'h6F;
        default: glyph = 8'h00;
      endcase
    end
  end
endmodule

module seg_scan_ctrl #(
  parameter int SCAN_DIV     = 200,
  parameter int BLANK_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic        value_valid,
  output logic        value_ready,
  output logic        busy,
  output logic        overflow,
  output logic        sel1,
  output logic        sel2,
  output logic        sel3,
  output logic        sel4,
  output logic [7:0]  seg
);
  localparam int NUM_DIGITS = 4;
  localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);
  localparam logic [15:0] BLANK_N  = 16'(BLANK_CYCLES);

  typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;

  state_t state, state_nxt;

  logic [15:0]                 bin_q;
  logic [NUM_DIGITS-1:0][3:0]  bcd_q;
  logic [NUM_DIGITS-1:0][3:0]  bcd_adj;
  logic [31:0]                 dd_shift;
  logic [3:0]                  step_q;
  logic                        ovf_pend_q;
  logic [NUM_DIGITS-1:0][3:0]  disp_q;
  logic                        ovf_q;

  // ---------------- conversion FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    value_ready = 1'b0;
    busy        = 1'b0;
    unique case (state)
      IDLE: begin
        value_ready = 1'b1;
        if (value_valid) state_nxt = CONVERT;
      end
      CONVERT: begin
        busy = 1'b1;
        if (step_q == 4'd15) state_nxt = COMMIT;
      end
      COMMIT: begin
        busy      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  genvar i;
  generate
    for (i = 0; i < NUM_DIGITS; i++) begin : g_adj
      assign bcd_adj[i] = (bcd_q[i] >= 4'd5) ? bcd_q[i] + 4'd3 : bcd_q[i];
    end
  endgenerate

  assign dd_shift = {bcd_adj, bin_q} << 1;

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q      <= '0;
      bcd_q      <= '0;
      step_q     <= '0;
      ovf_pend_q <= 1'b0;
      disp_q     <= '0;
      ovf_q      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (value_valid) begin
          bin_q      <= value;
          bcd_q      <= '0;
          step_q     <= '0;
          ovf_pend_q <= (value > 16'd9999);
        end
        CONVERT: begin
          bcd_q  <= dd_shift[31:16];
          bin_q  <= dd_shift[15:0];
          step_q <= step_q + 4'd1;
        end
        // Display only changes here, so a scan never sees a half-built result.
        COMMIT: begin
          disp_q <= bcd_q;
          ovf_q  <= ovf_pend_q;
        end
        default: ;
      endcase
    end
  end

  assign overflow = ovf_q;

  // ---------------- glyph lookup ----------------
  logic [NUM_DIGITS-1:0]      lz_blank;
  logic [NUM_DIGITS-1:0][7:0] glyphs;

`ifdef SEG_LZB_EN
  assign lz_blank[0] = 1'b0;
  generate
    for (i = 1; i < NUM_DIGITS; i++) begin : g_lzb
      assign lz_blank[i] = (disp_q[NUM_DIGITS-1:i] == '0);
    end
  endgenerate
`else
  assign lz_blank = '0;
`endif

  seg_glyph u_glyph [NUM_DIGITS-1:0] (
    .digit (disp_q),
    .ovf   ({NUM_DIGITS{ovf_q}}),
    .blank (lz_blank),
    .glyph (glyphs)
  );

  // ---------------- scan engine ----------------
  logic [15:0] slot_q;
  logic [1:0]  idx_q;
  logic [3:0]  sel_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q <= '0;
      idx_q  <= '0;
    end else if (slot_q == DIV_LAST) begin
      slot_q <= '0;
      idx_q  <= idx_q + 2'd1;
    end else begin
      slot_q <= slot_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q <= '0;
      seg   <= '0;
    end else if (slot_q < BLANK_N) begin
      sel_q <= '0;
      seg   <= '0;
    end else begin
      sel_q <= 4'b0001 << idx_q;
      seg   <= glyphs[idx_q];
    end
  end

  assign {sel4, sel3, sel2, sel1} = sel_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with a short scan (SCAN_DIV=4, BLANK_CYCLES=1).
module tb_seg_scan_ctrl;
  localparam int DIV = 4;
  localparam int BLK = 1;
`ifdef SEG_LZB_EN
  localparam logic [7:0] ZH = 8'h00;
`else
  localparam logic [7:0] ZH = 8'h3F;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value = '0;
  logic        value_valid = 1'b0;
  logic        value_ready, busy, overflow;
  logic        sel1, sel2, sel3, sel4;
  logic [7:0]  seg;
  logic [3:0]  sel;

  int n_chk = 0;
  int n_err = 0;

  assign sel = {sel4, sel3, sel2, sel1};

  seg_scan_ctrl #(.SCAN_DIV(DIV), .BLANK_CYCLES(BLK)) dut (
    .clk(clk), .rst(rst), .value(value), .value_valid(value_valid),
    .value_ready(value_ready), .busy(busy), .overflow(overflow),
    .sel1(sel1), .sel2(sel2), .sel3(sel3), .sel4(sel4), .seg(seg)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Offer v, then count cycles with busy high until the result commits.
  task automatic convert(input logic [15:0] v);
    int n;
    @(negedge clk);
    chk("ready_pre", value_ready, 1);
    value = v;
    value_valid = 1'b1;
    @(negedge clk);
    value_valid = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("busy_len", n, 17);
    chk("ready_post", value_ready, 1);
  endtask

  // g[0]=ones .. g[3]=thousands; checks one-hot sel, glyphs, blank length and rotation.
  task automatic scan_check(input logic [3:0][7:0] g, input int cycles);
    int         blank_run;
    logic [3:0] prev;
    int         idx;
    blank_run = 0;
    prev = '0;
    repeat (cycles) begin
      @(negedge clk);
      chk("onehot", ($countones(sel) <= 1), 1);
      if (sel == 4'b0000) begin
        chk("blank_seg", seg, 8'h00);
        blank_run++;
      end else begin
        idx = (sel == 4'b0001) ? 0 : (sel == 4'b0010) ? 1 : (sel == 4'b0100) ? 2 : 3;
        chk("glyph", seg, g[idx]);
        if (blank_run != 0) begin
          if (prev != 4'b0000) begin
            chk("blank_len", blank_run, BLK);
            chk("rotate", sel, {prev[2:0], prev[3]});
          end
          blank_run = 0;
        end
        prev = sel;
      end
    end
  endtask

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", value_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_sel", sel, 4'b0000);
    chk("rst_seg", seg, 8'h00);
    rst = 1'b0;
    scan_check({ZH, ZH, ZH, 8'h3F}, 3 * 4 * DIV);

    // latency and digit order
    convert(16'd1234);
    chk("ovf_1234", overflow, 0);
    scan_check({8'h06, 8'h5B, 8'h4F, 8'h66}, 3 * 4 * DIV);

    // overflow dashes, then back in range
    convert(16'd12345);
    chk("ovf_set", overflow, 1);
    scan_check({8'h40, 8'h40, 8'h40, 8'h40}, 2 * 4 * DIV);
    convert(16'd9999);
    chk("ovf_clr", overflow, 0);
    scan_check({8'h6F, 8'h6F, 8'h6F, 8'h6F}, 2 * 4 * DIV);

    // leading zeros
    convert(16'd40);
    scan_check({ZH, ZH, 8'h66, 8'h3F}, 2 * 4 * DIV);

    // valid toggled during conversion must be ignored
    @(negedge clk);
    value = 16'd1000;
    value_valid = 1'b1;
    @(negedge clk);
    value = 16'd5678;
    for (int k = 0; k < 10; k++) begin
      value_valid = ~value_valid;
      chk("ready_busy", value_ready, 0);
      @(negedge clk);
    end
    value_valid = 1'b0;
    for (int k = 0; k < 40 && busy; k++) @(negedge clk);
    chk("idle_1000", busy, 0);
    repeat (3) @(negedge clk);
    chk("no_accept", busy, 0);
    scan_check({8'h06, 8'h3F, 8'h3F, 8'h3F}, 2 * 4 * DIV);
    convert(16'd5678);
    scan_check({8'h6D, 8'h7D, 8'h07, 8'h7F}, 2 * 4 * DIV);

    // reset mid-conversion
    @(negedge clk);
    value = 16'd4321;
    value_valid = 1'b1;
    @(negedge clk);
    value_valid = 1'b0;
    repeat (7) @(negedge clk);
    chk("mid_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_ready", value_ready, 1);
    chk("mid_busy_clr", busy, 0);
    chk("mid_ovf", overflow, 0);
    scan_check({ZH, ZH, ZH, 8'h3F}, 2 * 4 * DIV);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
